// File: rtl/cdc_handshake_rx_if.sv
// cdc_handshake_rx_if: sender toggle/data and consumer valid/ready bundle for cdc_handshake_rx
interface cdc_handshake_rx_if #(
    parameter int DATA_WIDTH = 12
);
    logic                  req_tgl;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  ack_tgl;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic                  data_ready;
    logic                  pending;
    logic [15:0]           word_cnt;
    modport master (
        output req_tgl, data_in, data_ready,
        input  ack_tgl, data_out, data_valid, pending, word_cnt
    );
    modport slave (
        input  req_tgl, data_in, data_ready,
        output ack_tgl, data_out, data_valid, pending, word_cnt
    );
endinterface

// File: rtl/cdc_handshake_rx.sv
// cdc_handshake_rx: toggle-handshake CDC receiver with one-word output slot and stall on full slot.
// CDC_RX_SYNC3_EN selects a 3-stage request synchroniser instead of 2.
module cdc_handshake_rx #(
    parameter int DATA_WIDTH = 12
) (
    input logic               clk,
    input logic               rst_n,
    cdc_handshake_rx_if.slave bus
);
`ifdef CDC_RX_SYNC3_EN
    localparam int SYNC = 3;
`else
    localparam int SYNC = 2;
`endif
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] STALL = 1'b1;

    logic [SYNC-1:0]       r_sync;
    logic                  r_req_seen;
    logic                  r_ack;
    logic                  r_valid;
    logic                  r_pending;
    logic [0:0]            r_state;
    logic [0:0]            w_state_nx;
    logic [DATA_WIDTH-1:0] r_data;
    logic [15:0]           r_cnt;
    logic                  w_req_s;
    logic                  w_new;
    logic                  w_free;
    logic                  w_cap;

    assign w_req_s = r_sync[SYNC-1];
    assign w_new   = w_req_s ^ r_req_seen;
    assign w_free  = !r_valid || bus.data_ready;
    assign w_cap   = w_new && w_free;

    // STALL also falls back to IDLE if the sender withdraws its level (protocol violation)
    always_comb begin
        w_state_nx = (r_state == IDLE) ? ((w_new && !w_free) ? STALL : IDLE)
                                       : ((w_cap || !w_new) ? IDLE : STALL);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync     <= '0;
            r_req_seen <= 1'b0;
            r_ack      <= 1'b0;
            r_valid    <= 1'b0;
            r_pending  <= 1'b0;
            r_state    <= IDLE;
            r_data     <= '0;
            r_cnt      <= '0;
        end else begin
            r_sync    <= {r_sync[SYNC-2:0], bus.req_tgl};
            r_state   <= w_state_nx;
            r_pending <= (w_state_nx == STALL);
            r_valid   <= w_cap || (r_valid && !bus.data_ready);
            if (w_cap) begin
                r_data     <= bus.data_in;
                r_req_seen <= w_req_s;
                r_ack      <= w_req_s;
                r_cnt      <= r_cnt + 16'd1;
            end
        end
    end

    assign bus.ack_tgl    = r_ack;
    assign bus.data_out   = r_data;
    assign bus.data_valid = r_valid;
    assign bus.pending    = r_pending;
    assign bus.word_cnt   = r_cnt;
endmodule

// File: tb/tb_cdc_handshake_rx.sv
// tb_cdc_handshake_rx: scoreboard bench; sender pushes words, negedge monitor pops on each consume.
module tb_cdc_handshake_rx;
    localparam int DW = 12;
`ifdef CDC_RX_SYNC3_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    int            errors = 0;
    int            checks = 0;
    logic [DW-1:0] q[$];
    logic [15:0]   exp_cnt = 16'd0;
    bit            done = 1'b0;

    always #5 clk = ~clk;

    cdc_handshake_rx_if #(.DATA_WIDTH(DW)) bus ();
    cdc_handshake_rx #(.DATA_WIDTH(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack();
        int n = 0;
        while (bus.ack_tgl !== bus.req_tgl && n < 60) begin
            tick();
            n++;
        end
        if (bus.ack_tgl !== bus.req_tgl) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: got ack %0b expected %0b", bus.ack_tgl, bus.req_tgl);
        end
    endtask

    task automatic send(input logic [DW-1:0] w);
        wait_ack();
        bus.data_in = w;
        bus.req_tgl = ~bus.req_tgl;
        q.push_back(w);
        exp_cnt++;
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.data_valid && bus.data_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got %0h expected none", bus.data_out);
            end else begin
                chk("word_order", {20'd0, bus.data_out}, {20'd0, q.pop_front()});
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_tgl = 1'b0;
        bus.data_in = '0;
        bus.data_ready = 1'b1;
        tick();
        chk("rst_valid", {31'd0, bus.data_valid}, 0);
        chk("rst_data", {20'd0, bus.data_out}, 0);
        chk("rst_ack", {31'd0, bus.ack_tgl}, 0);
        chk("rst_pending", {31'd0, bus.pending}, 0);
        chk("rst_cnt", {16'd0, bus.word_cnt}, 0);
        tick();
        rst_n = 1'b1;

        bus.data_in = 12'hF0A;
        bus.req_tgl = 1'b1;
        q.push_back(12'hF0A);
        exp_cnt = 16'd1;
        for (int i = 1; i <= LAT; i++) begin
            tick();
            chk("lat_early_ack", {31'd0, bus.ack_tgl}, 0);
            chk("lat_early_valid", {31'd0, bus.data_valid}, 0);
        end
        tick();
        chk("lat_ack", {31'd0, bus.ack_tgl}, 1);
        chk("lat_data", {20'd0, bus.data_out}, 32'hF0A);
        chk("lat_valid", {31'd0, bus.data_valid}, 1);
        chk("lat_cnt", {16'd0, bus.word_cnt}, 1);
        tick();

        bus.data_ready = 1'b0;
        send(12'h123);
        wait_ack();
        chk("hold_data", {20'd0, bus.data_out}, 32'h123);
        chk("hold_valid", {31'd0, bus.data_valid}, 1);
        send(12'h456);
        repeat (LAT + 2) tick();
        chk("stall_pending", {31'd0, bus.pending}, 1);
        chk("stall_ack", {31'd0, bus.ack_tgl}, {31'd0, ~bus.req_tgl});
        chk("stall_data", {20'd0, bus.data_out}, 32'h123);
        bus.data_ready = 1'b1;
        tick();
        chk("unstall_data", {20'd0, bus.data_out}, 32'h456);
        chk("unstall_valid", {31'd0, bus.data_valid}, 1);
        chk("unstall_pending", {31'd0, bus.pending}, 0);
        chk("unstall_ack", {31'd0, bus.ack_tgl}, {31'd0, bus.req_tgl});
        chk("unstall_cnt", {16'd0, bus.word_cnt}, {16'd0, exp_cnt});

        for (int i = 0; i < 10; i++) begin
            send(12'($urandom));
            wait_ack();
            chk("b2b_cnt", {16'd0, bus.word_cnt}, {16'd0, exp_cnt});
        end

        tick();
        force dut.r_cnt = 16'hFFFE;
        tick();
        release dut.r_cnt;
        exp_cnt = 16'hFFFE;
        send(12'hABC);
        wait_ack();
        chk("cnt_ffff", {16'd0, bus.word_cnt}, {16'd0, exp_cnt});
        send(12'hDEF);
        wait_ack();
        chk("cnt_wrap", {16'd0, bus.word_cnt}, {16'd0, exp_cnt});

        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    repeat ($urandom_range(0, 3)) tick();
                    send(12'($urandom));
                end
                wait_ack();
                done = 1'b1;
            end
            begin
                while (!done) begin
                    bus.data_ready = 1'($urandom_range(0, 1));
                    tick();
                end
            end
        join
        bus.data_ready = 1'b1;
        for (int n = 0; n < 20 && q.size() > 0; n++) tick();
        chk("drain_empty", q.size(), 0);
        chk("rand_cnt", {16'd0, bus.word_cnt}, {16'd0, exp_cnt});

        if (bus.req_tgl == 1'b0) send(12'h0F0);
        wait_ack();
        repeat (2) tick();
        bus.data_ready = 1'b0;
        send(12'h111);
        wait_ack();
        send(12'h777);
        repeat (LAT + 2) tick();
        chk("rst_stall_pending", {31'd0, bus.pending}, 1);
        rst_n = 1'b0;
        q.delete();
        tick();
        chk("mid_rst_valid", {31'd0, bus.data_valid}, 0);
        chk("mid_rst_data", {20'd0, bus.data_out}, 0);
        chk("mid_rst_ack", {31'd0, bus.ack_tgl}, 0);
        chk("mid_rst_pending", {31'd0, bus.pending}, 0);
        chk("mid_rst_cnt", {16'd0, bus.word_cnt}, 0);
        rst_n = 1'b1;
        q.push_back(12'h777);
        exp_cnt = 16'd1;
        wait_ack();
        chk("post_rst_ack", {31'd0, bus.ack_tgl}, 1);
        chk("post_rst_data", {20'd0, bus.data_out}, 32'h777);
        chk("post_rst_valid", {31'd0, bus.data_valid}, 1);
        repeat (5) tick();
        chk("post_rst_once", {16'd0, bus.word_cnt}, {16'd0, exp_cnt});
        bus.data_ready = 1'b1;
        repeat (2) tick();
        chk("post_rst_drain", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cdc_handshake_rx.md
CDC_HANDSHAKE_RX -- requirements
Module: cdc_handshake_rx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 12, meaning width of transferred word (one 12-bit RGB colour or coordinate).
REQ-002 SHALL have port clk  input  1  receiving-domain clock; the block's only clock.
REQ-003 SHALL have port rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 SHALL have port req_tgl  input  1  request toggle from sender domain, asynchronous to clk; each level change = one new word.
REQ-005 SHALL have port data_in  input  DATA_WIDTH  sender word, guaranteed stable from before req_tgl changes until sender observes matching ack_tgl.
REQ-006 SHALL have port ack_tgl  output  1  acknowledge toggle returned to sender; equals last accepted req_tgl level.
REQ-007 SHALL have port data_out  output  DATA_WIDTH  captured word, registered.
REQ-008 SHALL have port data_valid  output  1  data_out holds an unconsumed word.
REQ-009 SHALL have port data_ready  input  1  consumer accepts data_out in any cycle where data_valid=1 and data_ready=1.
REQ-010 SHALL have port pending  output  1  request detected but held off because output slot full.
REQ-011 SHALL have port word_cnt  output  16  count of words accepted since reset.

Function
REQ-012 SHALL synchronise req_tgl through a chain of flops (2 stages by default) before any use; data_in SHALL never be synchronised, only sampled.
REQ-013 SHALL keep register req_seen; new request exists when synchronised req (req_s) differs from req_seen.
REQ-014 SHALL implement FSM states IDLE and STALL.
REQ-015 IDLE: if new request and slot free (data_valid=0 or data_ready=1) then on that edge data_out<=data_in, data_valid<=1, req_seen<=req_s, ack_tgl<=req_s, word_cnt+=1, stay IDLE.
REQ-016 IDLE: if new request and slot full (data_valid=1, data_ready=0) then go STALL, pending<=1, nothing captured.
REQ-017 STALL: on first cycle with data_ready=1, perform REQ-015 capture, pending<=0, return IDLE.
REQ-018 Consumer handshake: data_valid=1, data_ready=1 with no capture same edge SHALL clear data_valid; with capture same edge data_valid SHALL stay 1 carrying new word (back-to-back, zero bubble).
REQ-019 data_out SHALL change only on capture edges; held stable while data_valid=1 and data_ready=0.
REQ-020 Latency: req_tgl change before edge k -> capture and ack_tgl change on edge k+2 (2-stage) when slot free.
REQ-021 ack_tgl SHALL toggle exactly once per captured word; never for a stalled request until it is captured.
REQ-022 word_cnt SHALL wrap 0xFFFF -> 0x0000 without flag.
REQ-023 Toggle of req_tgl before ack returned is protocol violation; block SHALL take only the current req_s level, never produce more than one capture per req_seen change.

Reset
REQ-024 While rst_n=0 at rising clk: sync flops, req_seen, ack_tgl SHALL be 0; data_out 0; data_valid 0; pending 0; word_cnt 0; FSM IDLE.
REQ-025 Reset mid-transfer or mid-STALL SHALL discard held word and pending request; if req_tgl is 1 after reset release, block SHALL treat it as new request and capture after sync latency.

Configuration
REQ-026 Macro CDC_RX_SYNC3_EN defined: synchroniser SHALL be 3 stages, capture on edge k+3; undefined: 2 stages, edge k+2; all other behaviour identical.

Verification
REQ-027 Reset, req_tgl 0->1 with data_in=0xF0A, data_ready=1 -> edge k+2: data_out=0xF0A, data_valid=1, ack_tgl=1, word_cnt=1 (k+3 with CDC_RX_SYNC3_EN).
REQ-028 data_ready=0, word 0x123 held, second toggle with 0x456 -> pending=1, STALL, ack_tgl unchanged, data_out=0x123; raise data_ready -> same edge data_out=0x456, data_valid=1, pending=0, ack_tgl toggles.
REQ-029 Ten back-to-back transfers, sender toggling on each ack, data_ready=1 -> all ten words in order, word_cnt=10, no data_valid gap on coincident capture/consume edges.
REQ-030 Preload word_cnt path to 0xFFFF via 65535 transfers, one more -> word_cnt=0x0000.
REQ-031 rst_n=0 during STALL with data_valid=1 -> next edge all outputs zero; req_tgl left at 1 -> after release one capture, ack_tgl=1.
